// File: rtl/xs_sdr_rom_arbiter.sv
// xs_sdr_rom_arbiter: round-robin arbiter of OBJ/BG1/BG2 ROM reads onto one SDRAM controller read port
// Ports: CLK, RSTn (asynchronous, active-low)
//        sdr_{obj,bg1,bg2}_addr/_req : client fetch requests (level req, address held stable)
//        sdr_{obj,bg1,bg2}_rdy/_dout : one-cycle data-valid pulse and held read data per client
//        mem_addr/mem_req            : registered controller request, held until mem_ack
//        mem_ack/mem_dvalid/mem_dout : controller accept pulse, data-valid pulse, read data
// Optional feature macro XS_SDR_HIT_CACHE_EN: one-entry address tag per client, repeat reads answered locally.
module xs_sdr_rom_arbiter #(
    parameter int AW = 25,
    parameter int DW = 16
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic [AW-1:0] sdr_obj_addr,
    input  logic          sdr_obj_req,
    output logic          sdr_obj_rdy,
    output logic [DW-1:0] sdr_obj_dout,
    input  logic [AW-1:0] sdr_bg1_addr,
    input  logic          sdr_bg1_req,
    output logic          sdr_bg1_rdy,
    output logic [DW-1:0] sdr_bg1_dout,
    input  logic [AW-1:0] sdr_bg2_addr,
    input  logic          sdr_bg2_req,
    output logic          sdr_bg2_rdy,
    output logic [DW-1:0] sdr_bg2_dout,
    output logic [AW-1:0] mem_addr,
    output logic          mem_req,
    input  logic          mem_ack,
    input  logic          mem_dvalid,
    input  logic [DW-1:0] mem_dout
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nxt;
    logic [AW-1:0] addr [3];
    logic [DW-1:0] dout [3];
    logic [2:0] req, rdy, hit, pend;
    logic [1:0] ptr, grant, pick, c0, c1;
    logic issue, cap, done;
    assign addr = '{sdr_obj_addr, sdr_bg1_addr, sdr_bg2_addr};
    assign req = {sdr_bg2_req, sdr_bg1_req, sdr_obj_req};
    assign {sdr_bg2_rdy, sdr_bg1_rdy, sdr_obj_rdy} = rdy;
    assign sdr_obj_dout = dout[0];
    assign sdr_bg1_dout = dout[1];
    assign sdr_bg2_dout = dout[2];
    // A client's req is ignored in its own rdy cycle; tag hits never compete for the controller.
    assign pend = req & ~rdy & ~hit;
    // Search order starts just after the last-served client (ptr) and wraps back to it.
    assign c0 = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    assign c1 = (c0 == 2'd2) ? 2'd0 : c0 + 2'd1;
    assign pick = pend[c0] ? c0 : pend[c1] ? c1 : ptr;
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state <= IDLE;
        else       state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = |pend ? ISSUE : IDLE;
            ISSUE:   state_nxt = !mem_ack ? ISSUE : mem_dvalid ? RESP : WAIT;
            WAIT:    state_nxt = mem_dvalid ? RESP : WAIT;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        issue = state == IDLE && |pend;
        cap   = (state == ISSUE && mem_ack && mem_dvalid) || (state == WAIT && mem_dvalid);
        done  = state == RESP;
    end
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
            grant    <= 2'd0;
            ptr      <= 2'd2;
            rdy      <= '0;
            dout     <= '{default: '0};
        end else begin
            rdy <= hit | (cap ? 3'b001 << grant : 3'b000);
            if (cap) dout[grant] <= mem_dout;
            if (issue) begin
                mem_req  <= 1'b1;
                mem_addr <= addr[pick];
                grant    <= pick;
            end else if (state == ISSUE && mem_ack) begin
                mem_req <= 1'b0;
            end
            if (done) ptr <= grant;
        end
    end
`ifdef XS_SDR_HIT_CACHE_EN
    logic [AW-1:0] last_addr [3];
    logic [2:0] valid;
    // The granted client is excluded while its own miss is in flight; its dout is about to change.
    for (genvar g = 0; g < 3; g++) begin : g_hit
        assign hit[g] = req[g] && !rdy[g] && valid[g] && addr[g] == last_addr[g] &&
                        !(state != IDLE && grant == 2'(g));
    end
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            valid     <= '0;
            last_addr <= '{default: '0};
        end else if (cap) begin
            valid[grant]     <= 1'b1;
            last_addr[grant] <= mem_addr;
        end
    end
`else
    assign hit = '0;
`endif
endmodule

// File: tb/tb_xs_sdr_rom_arbiter.sv
// tb_xs_sdr_rom_arbiter: directed plus randomized check of xs_sdr_rom_arbiter against a transaction-level model
module tb_xs_sdr_rom_arbiter;
`ifdef XS_SDR_HIT_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif
    logic CLK = 1'b0, RSTn = 1'b1;
    logic [24:0] ca [3];
    logic [2:0] creq, crdy;
    logic o_rdy, b1_rdy, b2_rdy;
    logic [15:0] d0, d1, d2, mem_dout;
    logic [24:0] mem_addr;
    logic mem_req, mem_ack, mem_dvalid;
    int total = 0, bad = 0;
    assign crdy = {b2_rdy, b1_rdy, o_rdy};
    always #5 CLK = ~CLK;
    xs_sdr_rom_arbiter dut (
        .CLK(CLK), .RSTn(RSTn),
        .sdr_obj_addr(ca[0]), .sdr_obj_req(creq[0]), .sdr_obj_rdy(o_rdy), .sdr_obj_dout(d0),
        .sdr_bg1_addr(ca[1]), .sdr_bg1_req(creq[1]), .sdr_bg1_rdy(b1_rdy), .sdr_bg1_dout(d1),
        .sdr_bg2_addr(ca[2]), .sdr_bg2_req(creq[2]), .sdr_bg2_rdy(b2_rdy), .sdr_bg2_dout(d2),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack),
        .mem_dvalid(mem_dvalid), .mem_dout(mem_dout)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(negedge CLK);
    endtask
    function automatic logic [15:0] f(input logic [24:0] a);
        return a[15:0] ^ {a[24:17], a[7:0]} ^ 16'h5AC3;
    endfunction
    function automatic logic [15:0] dsel(input int i);
        return i == 0 ? d0 : i == 1 ? d1 : d2;
    endfunction
    function automatic logic [24:0] naddr();
        return 25'($urandom_range(0, 5)) << 5;
    endfunction
    task automatic run_random(input int n);
        int last_srv, busy, exp_miss, mc_phase, mc_cnt, g, max_age;
        int age [3];
        int served [$];
        logic [24:0] mc_addr;
        logic [24:0] tag [3];
        logic [24:0] snap_addr [3];
        logic [2:0] tag_v, snap_pend, exp_rdy, hit;
        last_srv = 2; busy = -1; exp_miss = -1; mc_phase = 0; mc_cnt = 0; max_age = 0;
        tag_v = '0; exp_rdy = '0; mc_addr = '0; hit = '0;
        age = '{0, 0, 0};
        tag = '{default: '0};
        RSTn = 1'b0; mem_ack = 1'b0; mem_dvalid = 1'b0; creq = '0;
        tick;
        RSTn = 1'b1;
        for (int i = 0; i < 3; i++) ca[i] = naddr();
        creq = 3'b111;
        snap_pend = 3'b111;
        snap_addr = ca;
        for (int c = 0; c < n; c++) begin
            tick;
            check("rdy", crdy, exp_rdy);
            for (int i = 0; i < 3; i++) if (crdy[i]) check("dout", dsel(i), f(ca[i]));
            if (exp_miss >= 0) begin
                served.push_back(exp_miss);
                last_srv = exp_miss;
                tag[exp_miss] = mc_addr;
                tag_v[exp_miss] = 1'b1;
                busy = -1;
            end
            exp_miss = -1;
            mem_ack = 1'b0;
            mem_dvalid = 1'b0;
            if (mc_phase == 0 && mem_req) begin
                g = -1;
                for (int k = 1; k <= 3; k++) if (g < 0 && snap_pend[(last_srv + k) % 3]) g = (last_srv + k) % 3;
                check("grant_any", g >= 0, 1);
                if (g >= 0) check("grant_addr", mem_addr, snap_addr[g]);
                busy = g;
                mc_addr = mem_addr;
                mc_phase = 1;
                mc_cnt = $urandom_range(0, 2);
            end else if (mc_phase != 0) begin
                check("req_level", mem_req, mc_phase == 1);
            end
            if (mc_phase == 1) begin
                if (mc_cnt == 0) begin
                    mem_ack = 1'b1;
                    if ($urandom_range(0, 2) == 0) begin
                        mem_dvalid = 1'b1; mem_dout = f(mc_addr); mc_phase = 0; exp_miss = busy;
                    end else begin
                        mc_phase = 2; mc_cnt = $urandom_range(0, 3);
                    end
                end else mc_cnt--;
            end else if (mc_phase == 2) begin
                if (mc_cnt == 0) begin
                    mem_dvalid = 1'b1; mem_dout = f(mc_addr); mc_phase = 0; exp_miss = busy;
                end else mc_cnt--;
            end
            for (int i = 0; i < 3; i++) begin
                if (crdy[i]) begin
                    age[i] = 0;
                    if ($urandom_range(0, 3) == 0) creq[i] = 1'b0;
                    else begin
                        creq[i] = 1'b1;
                        if ($urandom_range(0, 2) != 0) ca[i] = naddr();
                    end
                end else if (!creq[i] && $urandom_range(0, 2) == 0) begin
                    creq[i] = 1'b1; ca[i] = naddr(); age[i] = 0;
                end else if (creq[i]) begin
                    age[i]++;
                    if (age[i] > max_age) max_age = age[i];
                end
            end
            for (int i = 0; i < 3; i++) begin
                hit[i] = CACHE && creq[i] && !crdy[i] && tag_v[i] && ca[i] == tag[i] && busy != i;
                snap_pend[i] = creq[i] && !crdy[i] && !hit[i];
                snap_addr[i] = ca[i];
            end
            exp_rdy = (exp_miss >= 0 ? 3'(1 << exp_miss) : 3'b000) | hit;
        end
        check("rr_order", served.size() >= 3 ? served[0] * 16 + served[1] * 4 + served[2] : 99, 6);
        check("max_wait_ok", max_age <= 40, 1);
        check("served_some", served.size() > n / 20, 1);
    endtask
    initial begin
        creq = '0; ca = '{default: '0}; mem_ack = 1'b0; mem_dvalid = 1'b0; mem_dout = '0;
        #1 RSTn = 1'b0;
        repeat (2) tick;
        RSTn = 1'b1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rdy", crdy, 0);
        check("rst_dout", {d0, d1, d2}, 0);
        ca[0] = 25'h0012345; creq[0] = 1'b1;
        tick;
        check("t1_req", mem_req, 1);
        check("t1_addr", mem_addr, 25'h0012345);
        mem_ack = 1'b1; creq[0] = 1'b0;
        tick;
        mem_ack = 1'b0;
        check("t1_req_drop", mem_req, 0);
        mem_dvalid = 1'b1; mem_dout = 16'hBEEF;
        tick;
        mem_dvalid = 1'b0;
        check("t1_rdy", crdy, 3'b001);
        check("t1_dout", d0, 16'hBEEF);
        tick;
        check("t1_rdy_off", crdy, 0);
        ca[1] = 25'h55; creq[1] = 1'b1;
        tick;
        check("t4_req", mem_req, 1);
        check("t4_addr", mem_addr, 25'h55);
        mem_ack = 1'b1; mem_dvalid = 1'b1; mem_dout = 16'h1234; creq[1] = 1'b0;
        tick;
        mem_ack = 1'b0; mem_dvalid = 1'b0;
        check("t4_rdy", crdy, 3'b010);
        check("t4_dout", d1, 16'h1234);
        tick;
        ca[2] = 25'h77; creq[2] = 1'b1;
        tick;
        check("t5_req", mem_req, 1);
        mem_ack = 1'b1; creq[2] = 1'b0;
        tick;
        mem_ack = 1'b0;
        RSTn = 1'b0;
        #1 check("t5_async_req", mem_req, 0);
        tick;
        RSTn = 1'b1; mem_dvalid = 1'b1; mem_dout = 16'h7777;
        tick;
        mem_dvalid = 1'b0;
        check("t5_rdy", crdy, 0);
        check("t5_dout", {d0, d1, d2}, 0);
        check("t5_mem_req", mem_req, 0);
        tick;
        check("t5_rdy_late", crdy, 0);
        ca[2] = 25'h100; creq[2] = 1'b1;
        tick;
        check("t6_req1", mem_req, 1);
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0; mem_dvalid = 1'b1; mem_dout = 16'hA5A5;
        tick;
        mem_dvalid = 1'b0;
        check("t6_rdy1", crdy, 3'b100);
        check("t6_dout1", d2, 16'hA5A5);
        creq[2] = 1'b0; ca[0] = 25'h200; creq[0] = 1'b1;
        repeat (2) tick;
        check("t6_obj_req", mem_req, 1);
        check("t6_obj_addr", mem_addr, 25'h200);
        creq[2] = 1'b1; creq[0] = 1'b0;
        tick;
`ifdef XS_SDR_HIT_CACHE_EN
        check("t6_hit_rdy", crdy, 3'b100);
        check("t6_hit_dout", d2, 16'hA5A5);
        check("t6_hit_no_new_addr", mem_addr, 25'h200);
        creq[2] = 1'b0;
`else
        check("t6_no_hit", crdy, 0);
`endif
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0; mem_dvalid = 1'b1; mem_dout = 16'h3C3C;
        tick;
        mem_dvalid = 1'b0;
        check("t6_obj_rdy", crdy, 3'b001);
        check("t6_obj_dout", d0, 16'h3C3C);
        repeat (2) tick;
`ifdef XS_SDR_HIT_CACHE_EN
        check("t6_idle", mem_req, 0);
`else
        check("t6_second_req", mem_req, 1);
        check("t6_second_addr", mem_addr, 25'h100);
        mem_ack = 1'b1; mem_dvalid = 1'b1; mem_dout = 16'hA5A5; creq[2] = 1'b0;
        tick;
        mem_ack = 1'b0; mem_dvalid = 1'b0;
        check("t6_second_rdy", crdy, 3'b100);
`endif
        tick;
        run_random(4000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
